life_window_scanner: RTL

- Frame-scan controller for the banked Game-of-Life engine.
- Cell (x,y) lives in bank (y mod TILE)*TILE + (x mod TILE), at address (y/TILE)*WIDTH_BLOCKS + x/TILE.
- Each active cycle, rasters one centre cell, issues per-bank read addresses and enables for its 3x3 neighbourhood, and issues the delayed write of the centre cell's next state.
- Generalises the fixed-3x3 controller:
  - parametrised tile size and write latency,
  - start/busy/done handshake,
  - stall,
  - optional toroidal wrap.

---
 rtl/life_window_scanner.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/life_window_scanner.sv
// Frame-scan controller for the banked Game-of-Life engine: rasters centre cells, issues the
// banked 3x3 neighbourhood reads and the delayed centre write. LIFE_TORUS_WRAP_EN enables wrap.
module life_window_scanner #(
    parameter int unsigned TILE          = 3,
    parameter int unsigned WIDTH_BLOCKS  = 2,
    parameter int unsigned HEIGHT_BLOCKS = 2,
    parameter int unsigned ADDR_WIDTH    = 2,
    parameter int unsigned WRITE_LATENCY = 2
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              start,
    input  logic                              stall,
    input  logic                              wrap,
    output logic                              busy,
    output logic                              done,
    output logic [TILE*TILE-1:0]              read_enable,
    output logic [TILE*TILE*ADDR_WIDTH-1:0]   read_addr,
    output logic [TILE*TILE-1:0]              write_enable,
    output logic [ADDR_WIDTH-1:0]             write_addr,
    output logic                              frame_buffer_select
);
    localparam int unsigned NB = TILE * TILE;
    localparam int unsigned W  = TILE * WIDTH_BLOCKS;
    localparam int unsigned H  = TILE * HEIGHT_BLOCKS;
    localparam int unsigned BW = $clog2(NB);
    localparam int unsigned XW = $clog2(W);
    localparam int unsigned YW = $clog2(H);
    localparam int unsigned DW = 4;

    typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [XW-1:0]   cx_q, cx_d;
    logic [YW-1:0]   cy_q, cy_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            fbs_q, fbs_d;
    logic            issue;
    logic            last_window;
    logic            wrap_en;

`ifdef LIFE_TORUS_WRAP_EN
    assign wrap_en = wrap;
`else
    logic unused_wrap;
    assign unused_wrap = wrap;
    assign wrap_en     = 1'b0;
`endif

    assign issue       = (state_q == StScan) && !stall;
    assign last_window = (cx_q == XW'(W - 1)) && (cy_q == YW'(H - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cx_q    <= '0;
            cy_q    <= '0;
            drain_q <= '0;
            fbs_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            drain_q <= drain_d;
            fbs_q   <= fbs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        drain_d = drain_q;
        fbs_d   = fbs_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StScan;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            StScan: begin
                if (!stall) begin
                    if (last_window) begin
                        cx_d    = '0;
                        cy_d    = '0;
                        drain_d = '0;
                        state_d = (WRITE_LATENCY == 0) ? StDone : StDrain;
                    end else if (cx_q == XW'(W - 1)) begin
                        cx_d = '0;
                        cy_d = cy_q + 1'b1;
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (!stall) begin
                    if (drain_q == DW'(WRITE_LATENCY - 1)) state_d = StDone;
                    else drain_d = drain_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                fbs_d   = ~fbs_q;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StDone);
    end

    assign frame_buffer_select = fbs_q;

    // Neighbourhood decode: each of the 9 neighbours lands in a distinct bank since TILE >= 3.
    logic [NB-1:0]         rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr [NB];

    always_comb begin
        int            nx;
        int            ny;
        logic          inb;
        logic [BW-1:0] b;
        rd_en = '0;
        for (int i = 0; i < int'(NB); i++) rd_addr[i] = '0;
        nx  = 0;
        ny  = 0;
        inb = 1'b0;
        b   = '0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                nx = int'(cx_q) + dx;
                ny = int'(cy_q) + dy;
                if (wrap_en) begin
                    nx = (nx + int'(W)) % int'(W);
                    ny = (ny + int'(H)) % int'(H);
                end
                inb = (nx >= 0) && (nx < int'(W)) && (ny >= 0) && (ny < int'(H));
                if (inb && issue) begin
                    b = BW'((ny % int'(TILE)) * int'(TILE) + nx % int'(TILE));
                    rd_en[b]   = 1'b1;
                    rd_addr[b] = ADDR_WIDTH'((ny / int'(TILE)) * int'(WIDTH_BLOCKS)
                                             + nx / int'(TILE));
                end
            end
        end
    end

    assign read_enable = rd_en;
    for (genvar g = 0; g < int'(NB); g++) begin : g_pack
        assign read_addr[g*ADDR_WIDTH +: ADDR_WIDTH] = rd_addr[g];
    end

    logic [BW-1:0]         c_bank;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic                  wr_valid;
    logic [BW-1:0]         wr_bank;
    logic [ADDR_WIDTH-1:0] wr_addr;

    assign c_bank = BW'((int'(cy_q) % int'(TILE)) * int'(TILE) + int'(cx_q) % int'(TILE));
    assign c_addr = ADDR_WIDTH'((int'(cy_q) / int'(TILE)) * int'(WIDTH_BLOCKS)
                                + int'(cx_q) / int'(TILE));

    if (WRITE_LATENCY == 0) begin : g_wr_comb
        assign wr_valid = issue;
        assign wr_bank  = c_bank;
        assign wr_addr  = c_addr;
    end else begin : g_wr_pipe
        logic [WRITE_LATENCY-1:0] valid_q;
        logic [BW-1:0]            bank_q [WRITE_LATENCY];
        logic [ADDR_WIDTH-1:0]    addr_q [WRITE_LATENCY];

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                valid_q <= '0;
                for (int i = 0; i < int'(WRITE_LATENCY); i++) begin
                    bank_q[i] <= '0;
                    addr_q[i] <= '0;
                end
            end else if (!stall) begin
                valid_q[0] <= (state_q == StScan);
                bank_q[0]  <= c_bank;
                addr_q[0]  <= c_addr;
                for (int i = 1; i < int'(WRITE_LATENCY); i++) begin
                    valid_q[i] <= valid_q[i-1];
                    bank_q[i]  <= bank_q[i-1];
                    addr_q[i]  <= addr_q[i-1];
                end
            end
        end

        assign wr_valid = valid_q[WRITE_LATENCY-1];
        assign wr_bank  = bank_q[WRITE_LATENCY-1];
        assign wr_addr  = addr_q[WRITE_LATENCY-1];
    end

    always_comb begin
        write_enable = '0;
        if (wr_valid && !stall) write_enable[wr_bank] = 1'b1;
    end

    assign write_addr = wr_addr;

endmodule
